// File: rtl/bit_serializer_pkg.sv
// ============================================================================
// Module   : bit_serializer_pkg
// Brief    : Shared FSM encoding and idle line level for the serializer and
//            the downstream sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Level driven on x when no word is in flight; keeps the detector quiet.
  localparam logic X_IDLE_LEVEL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/bit_serializer_if.sv
// ============================================================================
// Module   : bit_serializer_if
// Brief    : Load handshake plus serial output bundle of the bit serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             x;
  logic             busy;
  logic             last;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  x,
    input  busy,
    input  last
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output x,
    output busy,
    output last
  );

endinterface

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Brief    : Parallel-in, serial-out stage feeding the sequence detector's x.
//            Define SERIALIZER_LSB_FIRST_EN to emit din[0] first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             is_last;
  logic             accept;

`ifdef SERIALIZER_LSB_FIRST_EN
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return w >> 1;
  endfunction
`else
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return w << 1;
  endfunction
`endif

  assign is_last        = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign bus.load_ready = (state_q == IDLE) || is_last;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.x    = x_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.last = is_last;

  // x_q carries the bit on the wire; sr_q holds the bits still to come,
  // already aligned so head_bit() yields the next one.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    case (state_q)
      IDLE: begin
        x_d = X_IDLE_LEVEL;
        if (accept) begin
          state_d = SHIFT;
          x_d     = head_bit(bus.din);
          sr_d    = advance(bus.din);
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!is_last) begin
          x_d   = head_bit(sr_q);
          sr_d  = advance(sr_q);
          cnt_d = cnt_q + CW'(1);
        end else if (accept) begin
          // Reload on the final bit so the next word follows with no gap.
          x_d   = head_bit(bus.din);
          sr_d  = advance(bus.din);
          cnt_d = '0;
        end else begin
          state_d = IDLE;
          x_d     = X_IDLE_LEVEL;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = X_IDLE_LEVEL;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      x_q     <= X_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// Module   : tb_bit_serializer
// Brief    : Scoreboard bench for bit_serializer (either bit-order build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

  localparam int WIDTH = 8;

  typedef struct {
    logic b;
    logic l;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  exp_t cur;
  logic cur_valid = 1'b0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic tx_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  // Drive one cycle; the scoreboard predicts readiness from the bit currently
  // on x and enqueues a word's bits when it expects an accept.
  task automatic step(input logic lv, input logic [WIDTH-1:0] d,
                      output logic rdy_exp, output logic rdy_obs);
    bus.load_valid = lv;
    bus.din        = d;
    #1;
    rdy_exp = !cur_valid || cur.l;
    rdy_obs = bus.load_ready;
    if (lv && rdy_exp) begin
      for (int i = 0; i < WIDTH; i++) begin
        exp_t e;
        e.b = tx_bit(d, i);
        e.l = (i == WIDTH - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      cur       = sb.pop_front();
      cur_valid = 1'b1;
    end else begin
      cur.b     = 1'b0;
      cur.l     = 1'b0;
      cur_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.din        = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.x, bus.busy, bus.last, bus.load_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got x/busy/last/ready=%b exp=0001", c,
                 {bus.x, bus.busy, bus.last, bus.load_ready});
      end
    end
    #2;
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    cur_valid      = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.x, bus.busy, bus.last, bus.load_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release got x/busy/last/ready=%b exp=0001",
               {bus.x, bus.busy, bus.last, bus.load_ready});
    end
  endtask

  task automatic test_single_word();
    logic re, ro;
    logic [WIDTH-1:0] w;
    logic [7:0] pattern;
    pattern = 8'b1001_0000;
`ifdef SERIALIZER_LSB_FIRST_EN
    w = 8'b0000_1001;
`else
    w = 8'b1001_0000;
`endif
    for (int c = 0; c < 11; c++) begin
      step(c == 0, (c == 0) ? w : WIDTH'($urandom), re, ro);
      n_checks++;
      if (ro !== re) begin
        n_fail++;
        $display("FAIL single_ready cyc=%0d got=%b exp=%b", c, ro, re);
      end
      n_checks++;
      if ({bus.x, bus.busy, bus.last} !== {cur_valid & cur.b, cur_valid, cur_valid & cur.l}) begin
        n_fail++;
        $display("FAIL single_out cyc=%0d got x/busy/last=%b exp=%b", c + 1,
                 {bus.x, bus.busy, bus.last}, {cur_valid & cur.b, cur_valid, cur_valid & cur.l});
      end
      // Same wire pattern is expected in both bit-order builds.
      n_checks++;
      if (bus.x !== ((c < 8) ? pattern[7-c] : 1'b0)) begin
        n_fail++;
        $display("FAIL single_pattern cyc=%0d got x=%b exp=%b", c + 1, bus.x,
                 (c < 8) ? pattern[7-c] : 1'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic re, ro;
    for (int c = 0; c < 26; c++) begin
      step(c < 16, (c < 8) ? 8'hA5 : 8'h3C, re, ro);
      n_checks++;
      if (ro !== re) begin
        n_fail++;
        $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, ro, re);
      end
      n_checks++;
      if ({bus.x, bus.busy, bus.last} !== {cur_valid & cur.b, cur_valid, cur_valid & cur.l}) begin
        n_fail++;
        $display("FAIL b2b_out cyc=%0d got x/busy/last=%b exp=%b", c + 1,
                 {bus.x, bus.busy, bus.last}, {cur_valid & cur.b, cur_valid, cur_valid & cur.l});
      end
    end
  endtask

  task automatic test_backpressure();
    logic re, ro;
    for (int c = 0; c < 14; c++) begin
      step((c == 0) || (c == 3), (c == 0) ? 8'h5A : 8'hFF, re, ro);
      n_checks++;
      if (ro !== re) begin
        n_fail++;
        $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, ro, re);
      end
      n_checks++;
      if ({bus.x, bus.busy, bus.last} !== {cur_valid & cur.b, cur_valid, cur_valid & cur.l}) begin
        n_fail++;
        $display("FAIL bp_out cyc=%0d got x/busy/last=%b exp=%b", c + 1,
                 {bus.x, bus.busy, bus.last}, {cur_valid & cur.b, cur_valid, cur_valid & cur.l});
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic re, ro;
    // Four bits of 8'hF0 go out, so x is high (MSB-first) when reset hits.
    for (int c = 0; c < 4; c++) begin
      step(c == 0, 8'hF0, re, ro);
      n_checks++;
      if ({bus.x, bus.busy, bus.last} !== {cur_valid & cur.b, cur_valid, cur_valid & cur.l}) begin
        n_fail++;
        $display("FAIL midrst_pre cyc=%0d got x/busy/last=%b exp=%b", c + 1,
                 {bus.x, bus.busy, bus.last}, {cur_valid & cur.b, cur_valid, cur_valid & cur.l});
      end
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.x, bus.busy, bus.last, bus.load_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_async got x/busy/last/ready=%b exp=0001",
               {bus.x, bus.busy, bus.last, bus.load_ready});
    end
    sb.delete();
    cur_valid = 1'b0;
    cur.b     = 1'b0;
    cur.l     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.load_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_release got busy/ready=%b exp=01", {bus.busy, bus.load_ready});
    end
    for (int c = 0; c < 10; c++) begin
      step(c == 0, 8'h81, re, ro);
      n_checks++;
      if (ro !== re) begin
        n_fail++;
        $display("FAIL midrst_ready cyc=%0d got=%b exp=%b", c, ro, re);
      end
      n_checks++;
      if ({bus.x, bus.busy, bus.last} !== {cur_valid & cur.b, cur_valid, cur_valid & cur.l}) begin
        n_fail++;
        $display("FAIL midrst_out cyc=%0d got x/busy/last=%b exp=%b", c + 1,
                 {bus.x, bus.busy, bus.last}, {cur_valid & cur.b, cur_valid, cur_valid & cur.l});
      end
    end
  endtask

  initial begin
    cur.b = 1'b0;
    cur.l = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
